// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller for the five-stage core.
// It merges three requests into the per-stage stall vector:
//   - the load-use stall request from decode,
//   - multi-cycle EX sequencing, driven by an internal down-counter,
//   - exception flushes from MEM, which redirect the PC.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned MCYC_LEN   = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        mc_start_ex,
    input  logic        exc_req_mem,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam int unsigned   CNT_W    = $clog2(MCYC_LEN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MCYC_LEN - 2);
    localparam logic [5:0]    STALL_MC = 6'b001111;
    localparam logic [5:0]    STALL_LU = 6'b000111;

    typedef enum logic {
        IDLE = 1'b0,
        MC   = 1'b1
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rel_q;

    // Sequencing state. Exceptions abort any op in flight. The release flag
    // marks the cycle in which the finished op is still sitting in EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
        end else begin
            rel_q <= 1'b0;
            if (exc_req_mem) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (state_q == MC) begin
                if (cnt_q == CNT_W'(1)) begin
                    state_q <= IDLE;
                    rel_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end else if (mc_start_ex && !rel_q) begin
                if (MCYC_LEN > 2) begin
                    state_q <= MC;
                    cnt_q   <= CNT_LOAD;
                end else begin
                    rel_q <= 1'b1;
                end
            end
        end
    end

    // Zero-latency responses, decoded in priority order; forced low in reset.
    always_comb begin
        stall_o  = '0;
        flush_o  = 1'b0;
        new_pc_o = '0;
        busy_o   = 1'b0;
        if (rst) begin
            busy_o = (state_q == MC);
            if (exc_req_mem) begin
                flush_o  = 1'b1;
                new_pc_o = EXC_VECTOR;
            end else if (state_q == MC) begin
                stall_o = STALL_MC;
            end else if (mc_start_ex && !rel_q) begin
                stall_o = STALL_MC;
            end else if (stallreq_id) begin
                stall_o = STALL_LU;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Performance counters: stall cycles wrap, flush count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_o <= '0;
            flush_cnt_o    <= '0;
        end else begin
            if (stall_o != 6'b0) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (flush_o && (flush_cnt_o != 16'hFFFF)) begin
                flush_cnt_o <= flush_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl (MCYC_LEN=4, EXC_VECTOR=0x20). The driver issues one
// vector per cycle and queues the expected response; the monitor pops one
// entry each falling edge and compares it with what the DUT presents.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        mc_start_ex = 1'b0;
    logic        exc_req_mem = 1'b0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_cnt_o;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    pipe_ctrl #(
        .MCYC_LEN  (4),
        .EXC_VECTOR(32'h0000_0020)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .mc_start_ex (mc_start_ex),
        .exc_req_mem (exc_req_mem),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .new_pc_o    (new_pc_o),
        .busy_o      (busy_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: compare presented outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total = total + 1;
            if (stall_o !== e.stall || flush_o !== e.flush || new_pc_o !== e.pc || busy_o !== e.busy) begin
                bad = bad + 1;
                $display("FAIL vec%0d: got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                         total, stall_o, flush_o, new_pc_o, busy_o, e.stall, e.flush, e.pc, e.busy);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue its expectation.
    task automatic step(input logic r, input logic sreq, input logic mc, input logic exc,
                        input logic [5:0] es, input logic ef, input logic [31:0] epc,
                        input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        stallreq_id = sreq;
        mc_start_ex = mc;
        exc_req_mem = exc;
        e.stall = es;
        e.flush = ef;
        e.pc    = epc;
        e.busy  = eb;
        exp_q.push_back(e);
    endtask

    task automatic check_perf(input logic [31:0] es, input logic [15:0] ef);
`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk);
        #1;
        total = total + 1;
        if (stall_cycles_o !== es || flush_cnt_o !== ef) begin
            bad = bad + 1;
            $display("FAIL perf: got stall_cycles=%0d flush_cnt=%0d, want %0d %0d",
                     stall_cycles_o, flush_cnt_o, es, ef);
        end
`endif
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // In reset: requests asserted, outputs must stay 0.
        step(0, 1, 1, 1, 6'h00, 0, 32'h0, 0);
        step(0, 1, 1, 0, 6'h00, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);

        // Plain multi-cycle op: 3 stall cycles, busy in the last 2, release clean.
        step(1, 0, 1, 0, 6'h0F, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h0F, 0, 32'h0, 1);
        step(1, 0, 0, 0, 6'h0F, 0, 32'h0, 1);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);

        // Single-cycle load-use stall.
        step(1, 1, 0, 0, 6'h07, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);

        // Exception while MC has cnt==1: flush now, idle next cycle.
        step(1, 0, 1, 0, 6'h0F, 0, 32'h0,  0);
        step(1, 0, 0, 0, 6'h0F, 0, 32'h0,  1);
        step(1, 0, 0, 1, 6'h00, 1, 32'h20, 1);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0,  0);

        // Exception in IDLE beats a simultaneous start and load-use request.
        step(1, 1, 1, 1, 6'h00, 1, 32'h20, 0);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0,  0);

        // Start held through release, load-use in release: no restart.
        step(1, 0, 1, 0, 6'h0F, 0, 32'h0, 0);
        step(1, 0, 1, 0, 6'h0F, 0, 32'h0, 1);
        step(1, 1, 1, 0, 6'h0F, 0, 32'h0, 1);
        step(1, 1, 1, 0, 6'h07, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);

        // Stall cycles so far: 3 + 1 + 2 + 4 = 10; flushes: 2.
        check_perf(32'd10, 16'd2);

        // Reset two cycles into MC, then the FSM restarts from IDLE with rel=0.
        step(1, 0, 1, 0, 6'h0F, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h0F, 0, 32'h0, 1);
        step(0, 1, 0, 0, 6'h00, 0, 32'h0, 0);
        step(0, 0, 1, 0, 6'h00, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);
        step(1, 1, 0, 0, 6'h07, 0, 32'h0, 0);
        step(1, 0, 1, 0, 6'h0F, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'h0F, 0, 32'h0, 1);
        step(1, 0, 0, 0, 6'h0F, 0, 32'h0, 1);
        step(1, 0, 0, 0, 6'h00, 0, 32'h0, 0);

        // After reset: one load-use stall plus one 3-cycle op, no flushes.
        check_perf(32'd4, 16'd0);

        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
